// File: rtl/sp_tc_pkg.sv
// Shared types and widths for the sparse threadgroup sequencer.
// Operand widths match the spThreadgroup datapath ports.
package sp_tc_pkg;

   localparam int PSUM_W       = 16;
   localparam int WGRP_W       = 32;
   localparam int AGRP_W       = 64;
   localparam int IDX_W        = 8;
   localparam int FEDP_LAT_DEF = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
   } state_t;

endpackage

// File: rtl/sp_tg_sequencer.sv
// Steps one spThreadgroup through a k-step sparse reduction, feeding
// each result back as the next partial sum, then returns the four sums.
module sp_tg_sequencer
   import sp_tc_pkg::*;
#(
   parameter int FEDP_LAT = FEDP_LAT_DEF,
   parameter int KW       = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [KW-1:0]     k_steps,
   input  logic [PSUM_W-1:0] psum_init0,
   input  logic [PSUM_W-1:0] psum_init1,
   input  logic [PSUM_W-1:0] psum_init2,
   input  logic [PSUM_W-1:0] psum_init3,
   output logic              busy,
   output logic              done,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [WGRP_W-1:0] op_w0,
   input  logic [WGRP_W-1:0] op_w1,
   input  logic [IDX_W-1:0]  op_idx0,
   input  logic [IDX_W-1:0]  op_idx1,
   input  logic [AGRP_W-1:0] op_a0,
   input  logic [AGRP_W-1:0] op_a1,
   output logic [WGRP_W-1:0] tg_w0,
   output logic [WGRP_W-1:0] tg_w1,
   output logic [IDX_W-1:0]  tg_idx0,
   output logic [IDX_W-1:0]  tg_idx1,
   output logic [AGRP_W-1:0] tg_a0,
   output logic [AGRP_W-1:0] tg_a1,
   output logic [PSUM_W-1:0] tg_psum0,
   output logic [PSUM_W-1:0] tg_psum1,
   output logic [PSUM_W-1:0] tg_psum2,
   output logic [PSUM_W-1:0] tg_psum3,
   input  logic [PSUM_W-1:0] tg_result0,
   input  logic [PSUM_W-1:0] tg_result1,
   input  logic [PSUM_W-1:0] tg_result2,
   input  logic [PSUM_W-1:0] tg_result3,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PSUM_W-1:0] out_result0,
   output logic [PSUM_W-1:0] out_result1,
   output logic [PSUM_W-1:0] out_result2,
   output logic [PSUM_W-1:0] out_result3
);

   localparam int CW = 4;

   state_t            r_state;
   state_t            w_next;
   logic [KW-1:0]     r_k;
   logic [KW-1:0]     r_step;
   logic [CW-1:0]     r_wait;
   logic [PSUM_W-1:0] r_acc0;
   logic [PSUM_W-1:0] r_acc1;
   logic [PSUM_W-1:0] r_acc2;
   logic [PSUM_W-1:0] r_acc3;
   logic              w_fire;
   logic              w_ret;
   logic              w_last;

   assign w_fire = op_valid && (r_state == ST_ISSUE);
   // wait_cnt==1 marks the edge FEDP_LAT edges after the tg_* load
   assign w_ret  = (r_state == ST_WAIT) && (r_wait == CW'(1));
   assign w_last = (r_step == (r_k - KW'(1)));

   assign out_result0 = r_acc0;
   assign out_result1 = r_acc1;
   assign out_result2 = r_acc2;
   assign out_result3 = r_acc3;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next = (k_steps == '0) ? ST_DONE : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (op_valid) begin
               w_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (w_ret) begin
               w_next = w_last ? ST_DONE : ST_ISSUE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy      = 1'b1;
      op_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (r_state)
         ST_IDLE:  busy      = 1'b0;
         ST_ISSUE: op_ready  = 1'b1;
         ST_WAIT:  ;
         ST_DONE:  out_valid = 1'b1;
         default:  busy      = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done     <= 1'b0;
         r_k      <= '0;
         r_step   <= '0;
         r_wait   <= '0;
         r_acc0   <= '0;
         r_acc1   <= '0;
         r_acc2   <= '0;
         r_acc3   <= '0;
         tg_w0    <= '0;
         tg_w1    <= '0;
         tg_idx0  <= '0;
         tg_idx1  <= '0;
         tg_a0    <= '0;
         tg_a1    <= '0;
         tg_psum0 <= '0;
         tg_psum1 <= '0;
         tg_psum2 <= '0;
         tg_psum3 <= '0;
      end else begin
         done <= (r_state == ST_DONE) && out_ready;
         if ((r_state == ST_IDLE) && start) begin
            r_k    <= k_steps;
            r_step <= '0;
            r_acc0 <= psum_init0;
            r_acc1 <= psum_init1;
            r_acc2 <= psum_init2;
            r_acc3 <= psum_init3;
         end
         if (w_fire) begin
            tg_w0    <= op_w0;
            tg_w1    <= op_w1;
            tg_idx0  <= op_idx0;
            tg_idx1  <= op_idx1;
            tg_a0    <= op_a0;
            tg_a1    <= op_a1;
            tg_psum0 <= r_acc0;
            tg_psum1 <= r_acc1;
            tg_psum2 <= r_acc2;
            tg_psum3 <= r_acc3;
            r_wait   <= CW'(FEDP_LAT);
         end else if (r_state == ST_WAIT) begin
            r_wait <= r_wait - CW'(1);
         end
         if (w_ret) begin
            r_acc0 <= tg_result0;
            r_acc1 <= tg_result1;
            r_acc2 <= tg_result2;
            r_acc3 <= tg_result3;
            if (!w_last) begin
               r_step <= r_step + KW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_sp_tg_sequencer.sv
// Bench for sp_tg_sequencer with a delayed stub threadgroup and a
// closed-form model: result_N = init_N + k*10*(N+1) (mod 2^16).
module tb_sp_tg_sequencer;

   localparam int LAT = 2;
   localparam int KW  = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [KW-1:0] k_steps;
   logic [15:0]   psum_init0, psum_init1, psum_init2, psum_init3;
   logic          busy, done;
   logic          op_valid, op_ready;
   logic [31:0]   op_w0, op_w1;
   logic [7:0]    op_idx0, op_idx1;
   logic [63:0]   op_a0, op_a1;
   logic [31:0]   tg_w0, tg_w1;
   logic [7:0]    tg_idx0, tg_idx1;
   logic [63:0]   tg_a0, tg_a1;
   logic [15:0]   tg_psum0, tg_psum1, tg_psum2, tg_psum3;
   logic [15:0]   tg_result0, tg_result1, tg_result2, tg_result3;
   logic          out_valid, out_ready;
   logic [15:0]   out_result0, out_result1, out_result2, out_result3;

   always #5 clk = ~clk;

   sp_tg_sequencer #(.FEDP_LAT(LAT), .KW(KW)) dut (
      .clk(clk), .rst(rst), .start(start), .k_steps(k_steps),
      .psum_init0(psum_init0), .psum_init1(psum_init1),
      .psum_init2(psum_init2), .psum_init3(psum_init3),
      .busy(busy), .done(done),
      .op_valid(op_valid), .op_ready(op_ready),
      .op_w0(op_w0), .op_w1(op_w1), .op_idx0(op_idx0), .op_idx1(op_idx1),
      .op_a0(op_a0), .op_a1(op_a1),
      .tg_w0(tg_w0), .tg_w1(tg_w1), .tg_idx0(tg_idx0), .tg_idx1(tg_idx1),
      .tg_a0(tg_a0), .tg_a1(tg_a1),
      .tg_psum0(tg_psum0), .tg_psum1(tg_psum1),
      .tg_psum2(tg_psum2), .tg_psum3(tg_psum3),
      .tg_result0(tg_result0), .tg_result1(tg_result1),
      .tg_result2(tg_result2), .tg_result3(tg_result3),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result0(out_result0), .out_result1(out_result1),
      .out_result2(out_result2), .out_result3(out_result3)
   );

   // Stub threadgroup: one register stage, so a result appears exactly
   // on the edge LAT(=2) edges after tg_* load, and is stale before it.
   logic [15:0] sq0, sq1, sq2, sq3;
   always @(posedge clk) begin
      sq0 <= tg_psum0 + 16'd10;
      sq1 <= tg_psum1 + 16'd20;
      sq2 <= tg_psum2 + 16'd30;
      sq3 <= tg_psum3 + 16'd40;
   end
   assign tg_result0 = sq0;
   assign tg_result1 = sq1;
   assign tg_result2 = sq2;
   assign tg_result3 = sq3;

   int n_pass = 0;
   int n_tot  = 0;

   logic [15:0] e_res [4];
   int e_lat, e_nfire, e_opr;
   bit e_unst, e_tmo, e_done_ok, e_early;
   int fc [4];

   function automatic logic [339:0] all_outs();
      return {busy, done, op_ready, out_valid, tg_w0, tg_w1, tg_idx0,
              tg_idx1, tg_a0, tg_a1, tg_psum0, tg_psum1, tg_psum2,
              tg_psum3, out_result0, out_result1, out_result2, out_result3};
   endfunction

   function automatic logic [15:0] model(input logic [15:0] p, input int k,
                                         input int n);
      return p + 16'(k * 10 * (n + 1));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one reduction end to end and records what it observed.
   task automatic run_seq(input int k, input logic [15:0] p0, p1, p2, p3,
                          input int gap_beat, input int gap_len,
                          input int gap_pct, input int hold, input bit spam);
      logic [15:0] p [4];
      logic [31:0] dw0, dw1, xw0, xw1;
      logic [7:0]  di0, di1, xi0, xi1;
      logic [63:0] da0, da1, xa0, xa1;
      logic [15:0] dp [4];
      logic [15:0] xp [4];
      int cyc, gl, hl, budget;
      bit pend, have_x, seen, acc_pend, ov, fin;
      p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
      e_lat = -1; e_nfire = 0; e_opr = 0;
      e_unst = 0; e_tmo = 0; e_done_ok = 0; e_early = 0;
      for (int i = 0; i < 4; i++) fc[i] = -1;
      gl = gap_len; hl = hold;
      pend = 0; have_x = 0; seen = 0; acc_pend = 0; fin = 0;
      budget = 40 + k * (LAT + 1) * 4 + hold + gap_len;
      k_steps = KW'(k);
      psum_init0 = p0; psum_init1 = p1; psum_init2 = p2; psum_init3 = p3;
      out_ready = 0;
      cyc = 0;
      while (!fin) begin
         if (cyc > 0) begin
            if (pend) begin
               xw0 = dw0; xw1 = dw1; xi0 = di0; xi1 = di1;
               xa0 = da0; xa1 = da1; xp = dp; have_x = 1;
            end
            if (have_x && ({tg_w0, tg_w1, tg_idx0, tg_idx1, tg_a0, tg_a1,
                  tg_psum0, tg_psum1, tg_psum2, tg_psum3} !==
                  {xw0, xw1, xi0, xi1, xa0, xa1, xp[0], xp[1], xp[2], xp[3]}))
               e_unst = 1;
            if (acc_pend) begin
               out_ready = 0;
               e_done_ok = (done === 1'b1) && (out_valid === 1'b0) &&
                           (busy === 1'b0);
               tick();
               if (done !== 1'b0) e_done_ok = 0;
               fin = 1;
            end else begin
               if (done !== 1'b0) e_early = 1;
               if (out_valid === 1'b1) begin
                  if (!seen) begin
                     seen = 1; e_lat = cyc;
                     e_res[0] = out_result0; e_res[1] = out_result1;
                     e_res[2] = out_result2; e_res[3] = out_result3;
                  end else if ({out_result0, out_result1, out_result2,
                                out_result3} !== {e_res[0], e_res[1],
                                e_res[2], e_res[3]}) begin
                     e_unst = 1;
                  end
                  if (hl == 0) begin
                     out_ready = 1; acc_pend = 1;
                  end else begin
                     hl--;
                  end
               end
            end
         end
         if (!fin) begin
            if (op_ready === 1'b1) e_opr++;
            ov = 1;
            if (e_nfire == gap_beat && gl > 0 && op_ready === 1'b1) begin
               ov = 0; gl--;
            end
            if ($urandom_range(99) < gap_pct) ov = 0;
            op_valid = ov;
            op_w0 = $urandom; op_w1 = $urandom;
            op_idx0 = 8'($urandom); op_idx1 = 8'($urandom);
            op_a0 = {$urandom, $urandom}; op_a1 = {$urandom, $urandom};
            pend = ov && (op_ready === 1'b1);
            if (pend) begin
               dw0 = op_w0; dw1 = op_w1; di0 = op_idx0; di1 = op_idx1;
               da0 = op_a0; da1 = op_a1;
               for (int n = 0; n < 4; n++) dp[n] = model(p[n], e_nfire, n);
               if (e_nfire < 4) fc[e_nfire] = cyc;
               e_nfire++;
            end
            if (cyc == 0) start = 1;
            else start = (spam && !acc_pend) ? 1'($urandom) : 1'b0;
            if (cyc > budget) begin
               e_tmo = 1; fin = 1;
            end else begin
               tick();
               cyc++;
            end
         end
      end
      start = 0; op_valid = 0; out_ready = 0;
   endtask

   task automatic test_reset();
      rst = 1; start = 0; op_valid = 0; out_ready = 0; k_steps = '0;
      psum_init0 = 0; psum_init1 = 0; psum_init2 = 0; psum_init3 = 0;
      op_w0 = 0; op_w1 = 0; op_idx0 = 0; op_idx1 = 0; op_a0 = 0; op_a1 = 0;
      repeat (3) tick();
      n_tot++;
      if (all_outs() !== '0) $display("FAIL reset_outs got %h want 0", all_outs());
      else n_pass++;
      rst = 0;
      tick();
      n_tot++;
      if ({busy, op_ready, out_valid} !== 3'b000)
         $display("FAIL idle_flags got %b want 000", {busy, op_ready, out_valid});
      else n_pass++;
   endtask

   task automatic test_single();
      run_seq(1, 0, 0, 0, 0, -1, 0, 0, 0, 0);
      n_tot++;
      if (e_tmo) $display("FAIL k1_timeout got 1 want 0"); else n_pass++;
      n_tot++;
      if ({e_res[0], e_res[1], e_res[2], e_res[3]} !== {16'd10, 16'd20, 16'd30, 16'd40})
         $display("FAIL k1_results got %0d/%0d/%0d/%0d want 10/20/30/40",
                  e_res[0], e_res[1], e_res[2], e_res[3]);
      else n_pass++;
      n_tot++;
      if (e_lat != 1 + (LAT + 1)) $display("FAIL k1_latency got %0d want %0d", e_lat, 1 + (LAT + 1));
      else n_pass++;
      n_tot++;
      if (!e_done_ok || e_early) $display("FAIL k1_done got ok=%0d early=%0d want 1/0", e_done_ok, e_early);
      else n_pass++;
      n_tot++;
      if (e_unst) $display("FAIL k1_tg_load got unstable want stable"); else n_pass++;
   endtask

   task automatic test_k3();
      run_seq(3, -16'sd5, 0, 0, 0, -1, 0, 0, 0, 0);
      n_tot++;
      if (e_tmo) $display("FAIL k3_timeout got 1 want 0"); else n_pass++;
      n_tot++;
      if (e_res[0] !== 16'd25) $display("FAIL k3_res0 got %0d want 25", $signed(e_res[0]));
      else n_pass++;
      n_tot++;
      if (e_res[3] !== 16'd120) $display("FAIL k3_res3 got %0d want 120", e_res[3]);
      else n_pass++;
      n_tot++;
      if (e_opr != 3) $display("FAIL k3_ready_cycles got %0d want 3", e_opr);
      else n_pass++;
      n_tot++;
      if (fc[1] - fc[0] != LAT + 1 || fc[2] - fc[1] != LAT + 1)
         $display("FAIL k3_spacing got %0d,%0d want %0d", fc[1] - fc[0], fc[2] - fc[1], LAT + 1);
      else n_pass++;
      n_tot++;
      if (e_lat != 1 + 3 * (LAT + 1)) $display("FAIL k3_latency got %0d want %0d", e_lat, 1 + 3 * (LAT + 1));
      else n_pass++;
   endtask

   task automatic test_k0();
      run_seq(0, 7, 8, 9, 10, -1, 0, 0, 0, 0);
      n_tot++;
      if ({e_res[0], e_res[1], e_res[2], e_res[3]} !== {16'd7, 16'd8, 16'd9, 16'd10})
         $display("FAIL k0_results got %0d/%0d/%0d/%0d want 7/8/9/10",
                  e_res[0], e_res[1], e_res[2], e_res[3]);
      else n_pass++;
      n_tot++;
      if (e_lat != 1) $display("FAIL k0_latency got %0d want 1", e_lat); else n_pass++;
      n_tot++;
      if (e_opr != 0) $display("FAIL k0_no_ready got %0d want 0", e_opr); else n_pass++;
      n_tot++;
      if (!e_done_ok) $display("FAIL k0_done got 0 want 1"); else n_pass++;
   endtask

   task automatic test_gapped();
      logic [15:0] p [4];
      for (int n = 0; n < 4; n++) p[n] = 16'($urandom);
      run_seq(3, p[0], p[1], p[2], p[3], 1, 4, 0, 5, 1);
      n_tot++;
      if (e_unst || e_tmo) $display("FAIL gap_stable got unst=%0d tmo=%0d want 0/0", e_unst, e_tmo);
      else n_pass++;
      n_tot++;
      if (e_nfire != 3) $display("FAIL gap_beats got %0d want 3", e_nfire); else n_pass++;
      n_tot++;
      if (fc[1] - fc[0] != LAT + 1 + 4) $display("FAIL gap_spacing got %0d want %0d", fc[1] - fc[0], LAT + 5);
      else n_pass++;
      for (int n = 0; n < 4; n++) begin
         n_tot++;
         if (e_res[n] !== model(p[n], 3, n))
            $display("FAIL gap_res%0d got %0d want %0d", n, e_res[n], model(p[n], 3, n));
         else n_pass++;
      end
      n_tot++;
      if (!e_done_ok || e_early) $display("FAIL gap_done got ok=%0d early=%0d want 1/0", e_done_ok, e_early);
      else n_pass++;
   endtask

   task automatic test_wrap();
      run_seq(1, 16'd32760, 0, 0, 0, -1, 0, 0, 0, 0);
      n_tot++;
      if (e_res[0] !== 16'h8002) $display("FAIL wrap_res0 got %0d want -32766", $signed(e_res[0]));
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      k_steps = 8'd4; start = 1; op_valid = 1;
      psum_init0 = 1; psum_init1 = 2; psum_init2 = 3; psum_init3 = 4;
      tick();
      start = 0;
      repeat (4) tick();
      n_tot++;
      if ({busy, op_ready} !== 2'b10) $display("FAIL mid_in_wait got %b want 10", {busy, op_ready});
      else n_pass++;
      rst = 1;
      #1;
      n_tot++;
      if (all_outs() !== '0) $display("FAIL mid_rst_async got %h want 0", all_outs());
      else n_pass++;
      tick();
      n_tot++;
      if (all_outs() !== '0) $display("FAIL mid_rst_next got %h want 0", all_outs());
      else n_pass++;
      rst = 0; op_valid = 0;
      tick();
      run_seq(1, 0, 0, 0, 0, -1, 0, 0, 0, 0);
      n_tot++;
      if ({e_res[0], e_res[1], e_res[2], e_res[3]} !== {16'd10, 16'd20, 16'd30, 16'd40} || e_tmo)
         $display("FAIL mid_fresh got %0d/%0d/%0d/%0d want 10/20/30/40",
                  e_res[0], e_res[1], e_res[2], e_res[3]);
      else n_pass++;
   endtask

   task automatic test_max_k();
      run_seq(255, 0, 0, 0, 0, -1, 0, 0, 0, 0);
      n_tot++;
      if (e_nfire != 255 || e_tmo) $display("FAIL maxk_beats got %0d want 255", e_nfire);
      else n_pass++;
      n_tot++;
      if (e_res[0] !== 16'd2550 || e_res[3] !== 16'd10200)
         $display("FAIL maxk_res got %0d/%0d want 2550/10200", e_res[0], e_res[3]);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [15:0] p [4];
      int k;
      for (int it = 0; it < 8; it++) begin
         k = $urandom_range(0, 6);
         for (int n = 0; n < 4; n++) p[n] = 16'($urandom);
         run_seq(k, p[0], p[1], p[2], p[3], -1, 0, 30,
                 $urandom_range(0, 3), 1'($urandom));
         n_tot++;
         if (e_tmo || e_unst || e_nfire != k)
            $display("FAIL rnd%0d_flow got tmo=%0d unst=%0d beats=%0d want 0/0/%0d",
                     it, e_tmo, e_unst, e_nfire, k);
         else n_pass++;
         n_tot++;
         if ({e_res[0], e_res[1], e_res[2], e_res[3]} !==
             {model(p[0], k, 0), model(p[1], k, 1), model(p[2], k, 2), model(p[3], k, 3)})
            $display("FAIL rnd%0d_res got %h%h%h%h want %h%h%h%h", it,
                     e_res[0], e_res[1], e_res[2], e_res[3], model(p[0], k, 0),
                     model(p[1], k, 1), model(p[2], k, 2), model(p[3], k, 3));
         else n_pass++;
         n_tot++;
         if (!e_done_ok || e_early) $display("FAIL rnd%0d_done got ok=%0d early=%0d want 1/0", it, e_done_ok, e_early);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_k3();
      test_k0();
      test_gapped();
      test_wrap();
      test_reset_mid();
      test_max_k();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
